// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial stage feeding a sequence detector. Accepts WIDTH-bit
// words over a valid/ready handshake and emits them one bit per clock on w,
// qualified by w_valid. Back-to-back words stream with no bubble because a
// new word can be taken on the same edge that retires the last bit.
//
// Optional feature (compile-time macro SER_PARITY_EN):
//   defined   -> one even-parity bit (^din) follows the WIDTH data bits
//   undefined -> exactly WIDTH bits per word, no parity logic
//
// Parameters:
//   WIDTH      bits per accepted word (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] first, 0: din[0] first
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   din        in   parallel word to serialize
//   din_valid  in   din holds a valid word
//   din_ready  out  word can be accepted this cycle (combinational)
//   w          out  serial bit (registered)
//   w_valid    out  w carries a payload/parity bit (registered)
//   done       out  final bit of a word is on w (registered, 1-cycle pulse)
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             done
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;

  // First bit of a freshly accepted word.
  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction

  // Bit number 'pos' in transmit order. sr is held constant for the whole
  // word, so the count selects the bit instead of shifting the register.
  function automatic logic bit_at(input logic [WIDTH-1:0] d,
                                  input logic [CW-1:0]    pos);
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    shl = d << pos;
    shr = d >> pos;
    return MSB_FIRST ? shl[WIDTH-1] : shr[0];
  endfunction

  // cnt counts bits already presented on w; at NBITS the last bit is out.
  assign last_bit  = (cnt_q == CNT_LAST);
  assign din_ready = (state_q == IDLE) || ((state_q == SHIFT) && last_bit);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    done_d    = 1'b0;

    if (accept) begin
      // Same load path from IDLE and from the last-bit cycle: zero bubble.
      state_d   = SHIFT;
      sr_d      = din;
      cnt_d     = CW'(1);
      w_d       = first_bit(din);
      w_valid_d = 1'b1;
      done_d    = (NBITS == 1) ? 1'b1 : 1'b0;
    end else if ((state_q == SHIFT) && !last_bit) begin
      cnt_d     = cnt_q + 1'b1;
      w_valid_d = 1'b1;
      done_d    = ((cnt_q + 1'b1) == CNT_LAST);
      w_d       = bit_at(sr_q, cnt_q);
`ifdef SER_PARITY_EN
      if (cnt_q == CW'(WIDTH)) begin
        w_d = ^sr_q;
      end
`endif
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//
// Directed bench for bit_serializer. One instance is MSB-first, a second is
// LSB-first (used for the LSB/parity scenario). Inputs change and outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_m, din_l;
  logic       valid_m, valid_l;
  logic       ready_m, ready_l;
  logic       w_m, w_l;
  logic       wv_m, wv_l;
  logic       done_m, done_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(valid_m),
    .din_ready(ready_m), .w(w_m), .w_valid(wv_m), .done(done_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(valid_l),
    .din_ready(ready_l), .w(w_l), .w_valid(wv_l), .done(done_l)
  );

  task automatic test_reset();
    rst = 1'b1; valid_m = 1'b1; din_m = 8'hA5; valid_l = 1'b1; din_l = 8'h07;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({w_m, wv_m, done_m, ready_m} !== 4'b0001) begin
        failures++;
        $display("FAIL reset_msb c=%0d got w/wv/done/rdy=%b exp=0001", c, {w_m, wv_m, done_m, ready_m});
      end
      checks++;
      if ({w_l, wv_l, done_l, ready_l} !== 4'b0001) begin
        failures++;
        $display("FAIL reset_lsb c=%0d got w/wv/done/rdy=%b exp=0001", c, {w_l, wv_l, done_l, ready_l});
      end
    end
    @(negedge clk);
    rst = 1'b0; valid_m = 1'b0; valid_l = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_m, wv_m, done_m, ready_m} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release got w/wv/done/rdy=%b exp=0001", {w_m, wv_m, done_m, ready_m});
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    exp = 8'hA5;
    @(negedge clk);
    din_m = exp; valid_m = 1'b1;
    checks++;
    if (ready_m !== 1'b1) begin
      failures++;
      $display("FAIL single_ready0 got=%b exp=1", ready_m);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      valid_m = 1'b0;
      checks++;
      if ({w_m, wv_m, done_m} !== {exp[8-c], 1'b1, (c == 8)}) begin
        failures++;
        $display("FAIL single_bit c=%0d got w/wv/done=%b exp=%b", c, {w_m, wv_m, done_m}, {exp[8-c], 1'b1, (c == 8)});
      end
    end
    @(negedge clk);
    checks++;
    if ({w_m, wv_m, done_m} !== 3'b000) begin
      failures++;
      $display("FAIL single_after got w/wv/done=%b exp=000", {w_m, wv_m, done_m});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'hF00F;
    @(negedge clk);
    din_m = 8'hF0; valid_m = 1'b1;
    checks++;
    if (ready_m !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready0 got=%b exp=1", ready_m);
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if ({w_m, wv_m, done_m, ready_m} !== {exp[16-c], 1'b1, (c == 8 || c == 16), (c == 8 || c == 16)}) begin
        failures++;
        $display("FAIL b2b_bit c=%0d got w/wv/done/rdy=%b exp=%b", c, {w_m, wv_m, done_m, ready_m},
                 {exp[16-c], 1'b1, (c == 8 || c == 16), (c == 8 || c == 16)});
      end
      if (c == 1)  din_m = 8'h0F;
      if (c == 16) valid_m = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({w_m, wv_m} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_after got w/wv=%b exp=00", {w_m, wv_m});
    end
  endtask

  task automatic test_stall_ignore();
    @(negedge clk);
    din_m = 8'h00; valid_m = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if ({w_m, wv_m, ready_m} !== {1'b0, 1'b1, (c == 8)}) begin
        failures++;
        $display("FAIL stall_bit c=%0d got w/wv/rdy=%b exp=%b", c, {w_m, wv_m, ready_m}, {1'b0, 1'b1, (c == 8)});
      end
      if (c == 1) valid_m = 1'b0;
      if (c == 2) begin din_m = 8'hFF; valid_m = 1'b1; end
    end
    for (int c = 9; c <= 16; c++) begin
      @(negedge clk);
      valid_m = 1'b0;
      checks++;
      if ({w_m, wv_m, done_m} !== {1'b1, 1'b1, (c == 16)}) begin
        failures++;
        $display("FAIL stall_ff c=%0d got w/wv/done=%b exp=%b", c, {w_m, wv_m, done_m}, {1'b1, 1'b1, (c == 16)});
      end
    end
    @(negedge clk);
    checks++;
    if (wv_m !== 1'b0) begin
      failures++;
      $display("FAIL stall_after got wv=%b exp=0", wv_m);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp;
    exp = 8'hC3;
    @(negedge clk);
    din_m = exp; valid_m = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      valid_m = 1'b0;
      checks++;
      if ({w_m, wv_m} !== {exp[8-c], 1'b1}) begin
        failures++;
        $display("FAIL midrst_bit c=%0d got w/wv=%b exp=%b", c, {w_m, wv_m}, {exp[8-c], 1'b1});
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({w_m, wv_m, done_m, ready_m} !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_async got w/wv/done/rdy=%b exp=0001", {w_m, wv_m, done_m, ready_m});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({w_m, wv_m} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_after c=%0d got w/wv=%b exp=00", c, {w_m, wv_m});
      end
    end
  endtask

  task automatic test_lsb_parity();
    // 8'h07 LSB first, then even parity of three ones = 1.
    logic [8:0] exp;
    exp = 9'b1_0000_0111;
    @(negedge clk);
    din_l = 8'h07; valid_l = 1'b1;
    checks++;
    if (ready_l !== 1'b1) begin
      failures++;
      $display("FAIL lsb_ready0 got=%b exp=1", ready_l);
    end
    for (int c = 1; c <= NB; c++) begin
      @(negedge clk);
      valid_l = 1'b0;
      checks++;
      if ({w_l, wv_l, done_l} !== {exp[c-1], 1'b1, (c == NB)}) begin
        failures++;
        $display("FAIL lsb_bit c=%0d got w/wv/done=%b exp=%b", c, {w_l, wv_l, done_l}, {exp[c-1], 1'b1, (c == NB)});
      end
    end
    @(negedge clk);
    checks++;
    if ({w_l, wv_l, done_l} !== 3'b000) begin
      failures++;
      $display("FAIL lsb_after got w/wv/done=%b exp=000", {w_l, wv_l, done_l});
    end
  endtask

  initial begin
    rst = 1'b1; din_m = '0; din_l = '0; valid_m = 1'b0; valid_l = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall_ignore();
    test_reset_mid_word();
    test_lsb_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
